// File: rtl/stopwatch_fnd_ctrl.sv
// 4-digit common-anode 7-segment driver for the stopwatch: scans the digits,
// shows SEC.MSEC or HOUR.MIN from a per-frame snapshot and blinks the centre dp.
module stopwatch_fnd_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mode,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int PRESC_MAX = CLK_FREQ / SCAN_HZ - 1;
  localparam int PW = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_MAX);

  // floor(v/10) as (v*205)>>11, exact for every 7-bit value
  function automatic logic [3:0] div10(input logic [6:0] v);
    logic [14:0] p;
    p = {8'd0, v} * 15'd205;
    return p[14:11];
  endfunction

  function automatic logic [3:0] mod10(input logic [6:0] v);
    logic [6:0] r;
    r = v - ({3'd0, div10(v)} * 7'd10);
    return r[3:0];
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  logic [PW-1:0] presc_r;
  logic [1:0]    digit_sel_r;
  logic          mode_r;
  logic [6:0]    msec_r;
  logic [5:0]    sec_r;
  logic [5:0]    min_r;
  logic [4:0]    hour_r;
  logic [3:0]    fnd_com_r;
  logic [7:0]    fnd_data_r;

  logic          scan_tick_s;
  logic          frame_end_s;
  logic [6:0]    hi_s;
  logic [6:0]    lo_s;
  logic [3:0]    digit_s;
  logic          dp_on_s;
  logic [7:0]    seg_s;

  assign scan_tick_s = (presc_r == PRESC_LAST);
  assign frame_end_s = scan_tick_s && (digit_sel_r == 2'd3);

  // page select from the frozen snapshot, never from the live inputs
  always_comb begin
    hi_s = 7'd0;
    lo_s = 7'd0;
    if (mode_r) begin
      hi_s = {2'b00, hour_r};
      lo_s = {1'b0, min_r};
    end else begin
      hi_s = {1'b0, sec_r};
      lo_s = msec_r;
    end
  end

  always_comb begin
    digit_s = 4'd0;
    dp_on_s = 1'b0;
    seg_s   = 8'hFF;
    case (digit_sel_r)
      2'd0:    digit_s = mod10(lo_s);
      2'd1:    digit_s = div10(lo_s);
      2'd2:    digit_s = mod10(hi_s);
      2'd3:    digit_s = div10(hi_s);
      default: digit_s = 4'd0;
    endcase
    dp_on_s = (digit_sel_r == 2'd2) && (msec_r >= 7'd50);
    if (dp_on_s) begin
      seg_s = seg_code(digit_s) & 8'h7F;
    end else begin
      seg_s = seg_code(digit_s);
    end
  end

  // scan timing, snapshot at frame boundary, and the output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r     <= '0;
      digit_sel_r <= 2'd0;
      mode_r      <= 1'b0;
      msec_r      <= 7'd0;
      sec_r       <= 6'd0;
      min_r       <= 6'd0;
      hour_r      <= 5'd0;
      fnd_com_r   <= 4'b1110;
      fnd_data_r  <= 8'hC0;
    end else begin
      if (scan_tick_s) begin
        presc_r     <= '0;
        digit_sel_r <= digit_sel_r + 2'd1;
      end else begin
        presc_r     <= presc_r + PW'(1);
      end
      if (frame_end_s) begin
        mode_r <= i_mode;
        msec_r <= msec;
        sec_r  <= sec;
        min_r  <= min;
        hour_r <= hour;
      end
      fnd_com_r  <= ~(4'b0001 << digit_sel_r);
      fnd_data_r <= seg_s;
    end
  end

  assign fnd_com  = fnd_com_r;
  assign fnd_data = fnd_data_r;

endmodule

// File: tb/tb_stopwatch_fnd_ctrl.sv
// Directed bench for stopwatch_fnd_ctrl with CLK_FREQ=1000, SCAN_HZ=100 (scan_tick every 10 clk).
// cyc counts rising edges since the last reset release; outputs are sampled on the falling edge.
module tb_stopwatch_fnd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_mode = 1'b0;
  logic [6:0] msec = 7'd0;
  logic [5:0] sec = 6'd0;
  logic [5:0] min = 6'd0;
  logic [4:0] hour = 5'd0;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  stopwatch_fnd_ctrl #(.CLK_FREQ(1000), .SCAN_HZ(100)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .msec(msec), .sec(sec),
    .min(min), .hour(hour), .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  task automatic goto(input int e);
    while (cyc < e) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
        tests_failed++;
        $display("FAIL reset_hold: com=%b data=%h expected 1110/c0", fnd_com, fnd_data);
      end
    end
    rst = 1'b1;
    cyc = 0;
    for (int e = 1; e <= 11; e++) begin
      logic [3:0] exp_com;
      goto(e);
      exp_com = (e <= 10) ? 4'b1110 : 4'b1101;
      tests_run++;
      if (fnd_com !== exp_com || fnd_data !== 8'hC0) begin
        tests_failed++;
        $display("FAIL reset_release e=%0d: com=%b data=%h expected %b/c0", e, fnd_com, fnd_data, exp_com);
      end
    end
  endtask

  task automatic test_mode0();
    logic [3:0] exp_com [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] exp_dat [4] = '{8'hF8, 8'hB0, 8'hA4, 8'h99};
    i_mode = 1'b0;
    msec = 7'd37;
    sec = 6'd42;
    for (int d = 0; d < 4; d++) begin
      goto(45 + 10 * d);
      tests_run++;
      if (fnd_com !== exp_com[d] || fnd_data !== exp_dat[d]) begin
        tests_failed++;
        $display("FAIL mode0 d%0d: com=%b data=%h expected %b/%h", d, fnd_com, fnd_data, exp_com[d], exp_dat[d]);
      end
    end
  endtask

  task automatic test_mode1_dp();
    logic [3:0] exp_com [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] exp_dat [4] = '{8'h92, 8'hC0, 8'h30, 8'hA4};
    goto(76);
    i_mode = 1'b1;
    hour = 5'd23;
    min = 6'd5;
    msec = 7'd75;
    goto(78);
    tests_run++;
    if (fnd_com !== 4'b0111 || fnd_data !== 8'h99) begin
      tests_failed++;
      $display("FAIL mode_change_late: com=%b data=%h expected 0111/99", fnd_com, fnd_data);
    end
    for (int d = 0; d < 4; d++) begin
      goto(85 + 10 * d);
      tests_run++;
      if (fnd_com !== exp_com[d] || fnd_data !== exp_dat[d]) begin
        tests_failed++;
        $display("FAIL mode1 d%0d: com=%b data=%h expected %b/%h", d, fnd_com, fnd_data, exp_com[d], exp_dat[d]);
      end
    end
  endtask

  task automatic test_snapshot();
    goto(116);
    i_mode = 1'b0;
    msec = 7'd37;
    sec = 6'd42;
    goto(142);
    sec = 6'd43;
    goto(148);
    tests_run++;
    if (fnd_com !== 4'b1011 || fnd_data !== 8'hA4) begin
      tests_failed++;
      $display("FAIL snap_same_frame_d2: com=%b data=%h expected 1011/a4", fnd_com, fnd_data);
    end
    goto(155);
    tests_run++;
    if (fnd_com !== 4'b0111 || fnd_data !== 8'h99) begin
      tests_failed++;
      $display("FAIL snap_same_frame_d3: com=%b data=%h expected 0111/99", fnd_com, fnd_data);
    end
    goto(185);
    tests_run++;
    if (fnd_com !== 4'b1011 || fnd_data !== 8'hB0) begin
      tests_failed++;
      $display("FAIL snap_next_frame_d2: com=%b data=%h expected 1011/b0", fnd_com, fnd_data);
    end
    goto(195);
    tests_run++;
    if (fnd_com !== 4'b0111 || fnd_data !== 8'h99) begin
      tests_failed++;
      $display("FAIL snap_next_frame_d3: com=%b data=%h expected 0111/99", fnd_com, fnd_data);
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] exp_com [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int e = 201; e <= 320; e++) begin
      goto(e);
      tests_run++;
      if (fnd_com !== exp_com[((e - 1) / 10) % 4]) begin
        tests_failed++;
        $display("FAIL scan_order e=%0d: com=%b expected %b", e, fnd_com, exp_com[((e - 1) / 10) % 4]);
      end
      tests_run++;
      if ($countones(~fnd_com) !== 1) begin
        tests_failed++;
        $display("FAIL one_hot e=%0d: com=%b expected exactly one zero", e, fnd_com);
      end
    end
  endtask

  task automatic test_out_of_range_reset();
    i_mode = 1'b0;
    msec = 7'd120;
    sec = 6'd42;
    goto(365);
    tests_run++;
    if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
      tests_failed++;
      $display("FAIL oor_d0: com=%b data=%h expected 1110/c0", fnd_com, fnd_data);
    end
    goto(375);
    tests_run++;
    if (fnd_com !== 4'b1101 || (fnd_data !== 8'hFF && fnd_data !== 8'h7F)) begin
      tests_failed++;
      $display("FAIL oor_d1_blank: com=%b data=%h expected 1101/ff or 7f", fnd_com, fnd_data);
    end
    goto(385);
    tests_run++;
    if (fnd_com !== 4'b1011 || fnd_data !== 8'h24) begin
      tests_failed++;
      $display("FAIL oor_d2_dp: com=%b data=%h expected 1011/24", fnd_com, fnd_data);
    end
    goto(387);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
      tests_failed++;
      $display("FAIL midrun_reset_async: com=%b data=%h expected 1110/c0", fnd_com, fnd_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    goto(10);
    tests_run++;
    if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
      tests_failed++;
      $display("FAIL midrun_reset_e10: com=%b data=%h expected 1110/c0", fnd_com, fnd_data);
    end
    goto(11);
    tests_run++;
    if (fnd_com !== 4'b1101 || fnd_data !== 8'hC0) begin
      tests_failed++;
      $display("FAIL midrun_reset_e11: com=%b data=%h expected 1101/c0", fnd_com, fnd_data);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_dp();
    test_snapshot();
    test_scan_order();
    test_out_of_range_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1);
  end

endmodule
